// File: rtl/bounce_pkg.sv
// Shared types and constants for the switch-bounce emulator.
package bounce_pkg;

    // Burst controller states; encoding is visible on o_state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BOUNCE = 2'd1,
        SETTLE = 2'd2
    } t_bounce_state;

    // Galois feedback taps for the 16-bit pseudo-random source.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One Galois shift: shift right, fold the taps in when bit 0 falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        logic [15:0] shifted;
        shifted = q >> 1;
        return q[0] ? (shifted ^ LFSR_TAPS) : shifted;
    endfunction

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Galois LFSR; a nonzero seed keeps it off the all-zero state.
module lfsr_16
    import bounce_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [15:0] o_q
);

    // Advance once per clock; reset reloads the seed so sequences are repeatable.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_q <= SEED;
        end else begin
            o_q <= lfsr_next(o_q);
        end
    end

endmodule

// File: rtl/bounce_generator.sv
// Emulates a bouncy mechanical contact: on each commanded level change it emits
// a burst of pseudo-random glitches timed on a prescaled tick, then settles.
module bounce_generator
    import bounce_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 1_000,
    parameter int unsigned MAX_BOUNCES  = 8,
    parameter int unsigned SETTLE_TICKS = 16,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_level,
    input  logic       i_en,
    output logic       o_sw,
    output logic       o_busy,
    output logic [1:0] o_state,
    output logic       o_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned NB_W  = $clog2(MAX_BOUNCES);
    localparam int unsigned ST_W  = (SETTLE_TICKS > 0) ? $clog2(SETTLE_TICKS + 1) : 1;

    localparam logic [CNT_W-1:0] PRESC_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [ST_W-1:0]  SETTLE_LD = ST_W'(SETTLE_TICKS);

    // Prescaler
    logic [CNT_W-1:0] r_presc;
    logic             tick;

    // LFSR
    logic [15:0] lfsr_q;
    logic        unused_lfsr;

    // Burst controller state and next-state
    t_bounce_state r_state,  state_d;
    logic          r_sw,     sw_d;
    logic          r_level,  level_d;
    logic          r_target, target_d;
    logic [NB_W:0] r_count,  count_d;
    logic [2:0]    r_wait,   wait_d;
    logic [ST_W-1:0] r_settle, settle_d;

    logic [NB_W:0] count_load;
    logic [2:0]    wait_load;
    logic          sw_flip;

    // Free-running prescaler wrapping at TICK_DIV-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + CNT_W'(1);
        end
    end

    assign tick = (r_presc == PRESC_MAX);

    lfsr_16 #(
        .SEED (SEED)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_q     (lfsr_q)
    );

    // Only the low bits feed the burst parameters.
    assign unused_lfsr = ^lfsr_q[15:NB_W];

    // Glitch count 1..MAX_BOUNCES and interval 1..4 ticks, both from the current LFSR.
    assign count_load = (NB_W + 1)'(lfsr_q[NB_W-1:0]) + (NB_W + 1)'(1);
    assign wait_load  = {1'b0, lfsr_q[1:0]} + 3'd1;
    assign sw_flip    = !r_sw;

    // Next-state logic; a level change always wins over a coincident tick.
    always_comb begin
        state_d  = r_state;
        sw_d     = r_sw;
        level_d  = r_level;
        target_d = r_target;
        count_d  = r_count;
        wait_d   = r_wait;
        settle_d = r_settle;

        case (r_state)
            IDLE: begin
                sw_d = r_level;
                if (i_level != r_level) begin
                    target_d = i_level;
                    sw_d     = i_level;
                    if (i_en) begin
                        // First contact lands immediately; glitches follow on ticks.
                        state_d = BOUNCE;
                        count_d = count_load;
                        wait_d  = wait_load;
                    end else begin
                        level_d = i_level;
                    end
                end
            end

            BOUNCE: begin
                if (!i_en) begin
                    state_d  = IDLE;
                    level_d  = i_level;
                    target_d = i_level;
                    sw_d     = i_level;
                    count_d  = '0;
                    wait_d   = '0;
                    settle_d = '0;
                end else if (i_level != r_target) begin
                    // Retarget only; the burst keeps its count and timing.
                    target_d = i_level;
                end else if (tick) begin
                    if (r_wait <= 3'd1) begin
                        sw_d   = sw_flip;
                        wait_d = wait_load;
                        // A glitch is complete once the contact returns to target.
                        if (sw_flip == r_target) begin
                            if (r_count <= (NB_W + 1)'(1)) begin
                                count_d  = '0;
                                state_d  = SETTLE;
                                settle_d = SETTLE_LD;
                            end else begin
                                count_d = r_count - (NB_W + 1)'(1);
                            end
                        end
                    end else begin
                        wait_d = r_wait - 3'd1;
                    end
                end
            end

            SETTLE: begin
                sw_d = r_target;
                if (!i_en) begin
                    state_d  = IDLE;
                    level_d  = i_level;
                    target_d = i_level;
                    sw_d     = i_level;
                    count_d  = '0;
                    wait_d   = '0;
                    settle_d = '0;
                end else if (i_level != r_target) begin
                    // New command while settling starts a fresh burst.
                    state_d  = BOUNCE;
                    target_d = i_level;
                    sw_d     = i_level;
                    count_d  = count_load;
                    wait_d   = wait_load;
                    settle_d = '0;
                end else if (tick) begin
                    if (r_settle <= ST_W'(1)) begin
                        state_d  = IDLE;
                        level_d  = r_target;
                        settle_d = '0;
                    end else begin
                        settle_d = r_settle - ST_W'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                sw_d    = r_level;
            end
        endcase
    end

    // State registers; reset discards any burst in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_sw     <= 1'b0;
            r_level  <= 1'b0;
            r_target <= 1'b0;
            r_count  <= '0;
            r_wait   <= '0;
            r_settle <= '0;
        end else begin
            r_state  <= state_d;
            r_sw     <= sw_d;
            r_level  <= level_d;
            r_target <= target_d;
            r_count  <= count_d;
            r_wait   <= wait_d;
            r_settle <= settle_d;
        end
    end

    assign o_sw    = r_sw;
    assign o_busy  = (r_state != IDLE);
    assign o_state = r_state;
    assign o_tick  = tick;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator with a small LFSR model for burst sizes.
module tb_bounce_generator;

    localparam int unsigned TICK_DIV     = 4;
    localparam int unsigned MAX_BOUNCES  = 4;
    localparam int unsigned SETTLE_TICKS = 2;
    localparam logic [15:0] SEED         = 16'hACE1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       level = 1'b0;
    logic       en    = 1'b1;
    logic       sw;
    logic       busy;
    logic [1:0] state;
    logic       tick;

    int errors = 0;
    int checks = 0;

    int   edge_t[32];
    int   saved_t[32];
    int   n_edges;
    int   saved_n;
    int   busy_fall;
    logic done;
    int   n_pred;

    logic [15:0] m_lfsr;

    always #5 clk = ~clk;

    bounce_generator #(
        .TICK_DIV     (TICK_DIV),
        .MAX_BOUNCES  (MAX_BOUNCES),
        .SETTLE_TICKS (SETTLE_TICKS),
        .SEED         (SEED)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_level (level),
        .i_en    (en),
        .o_sw    (sw),
        .o_busy  (busy),
        .o_state (state),
        .o_tick  (tick)
    );

    // Reference LFSR used to predict burst length.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Record o_sw edges (negedge index from start) until busy drops; optional level flip.
    task automatic watch(input int max_cyc, input int flip_at);
        logic prev;
        logic seen;
        prev      = sw;
        seen      = 1'b0;
        n_edges   = 0;
        done      = 1'b0;
        busy_fall = 0;
        for (int c = 1; c <= max_cyc && !done; c++) begin
            @(negedge clk);
            if (sw !== prev) begin
                if (n_edges < 32) edge_t[n_edges] = c;
                n_edges++;
                prev = sw;
            end
            if (busy) seen = 1'b1;
            else if (seen) begin
                done      = 1'b1;
                busy_fall = c;
            end
            if (c == flip_at) level = ~level;
        end
        chk("watch_done", 32'(done), 32'(1));
    endtask

    // Drive a new level so that it is sampled on a tick edge; predict N.
    task automatic step_on_tick(input logic lvl, output int n);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        chk("tick_align", 32'(found), 32'(1));
        n     = int'(m_lfsr[1:0]) + 1;
        level = lvl;
    endtask

    initial begin
        int   d;
        int   last;
        logic found;

        // Reset state
        rst_n = 1'b0; level = 1'b0; en = 1'b1;
        #12;
        chk("rst_sw",    32'(sw),    32'(0));
        chk("rst_state", 32'(state), 32'(0));
        chk("rst_busy",  32'(busy),  32'(0));
        chk("rst_tick",  32'(tick),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Quiet input: idle, tick every 4 cycles
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            chk("idle_sw",    32'(sw),    32'(0));
            chk("idle_busy",  32'(busy),  32'(0));
            chk("idle_state", 32'(state), 32'(0));
            chk("idle_tick",  32'(tick),  32'(c % 4 == 3));
        end

        // Full burst 0->1, stepped on a tick edge
        step_on_tick(1'b1, n_pred);
        watch(400, 0);
        chk("b1_edges", 32'(n_edges), 32'(2 * n_pred + 1));
        chk("b1_first", 32'(edge_t[0]), 32'(1));
        if (n_edges >= 2) chk("b1_w1", 32'(edge_t[1] - edge_t[0]), 32'(4 * n_pred));
        for (int i = 0; i + 1 < n_edges && i < 31; i++) begin
            d = edge_t[i + 1] - edge_t[i];
            chk("b1_width_mod", 32'(d % 4), 32'(0));
            chk("b1_width_rng", 32'(d >= 4 && d <= 16), 32'(1));
        end
        chk("b1_final", 32'(sw), 32'(1));
        last = (n_edges > 0 && n_edges <= 32) ? n_edges - 1 : 0;
        chk("b1_busy_fall", 32'(busy_fall - edge_t[last]), 32'(8));

        // Enable low: clean follow with one-cycle latency
        en = 1'b0;
        @(negedge clk);
        level = 1'b0;
        #1 chk("en0_latency", 32'(sw), 32'(1));
        @(negedge clk);
        chk("en0_fall", 32'(sw), 32'(0));
        chk("en0_busy", 32'(busy), 32'(0));
        level = 1'b1;
        @(negedge clk);
        chk("en0_rise", 32'(sw), 32'(1));
        chk("en0_busy", 32'(busy), 32'(0));
        level = 1'b0;
        @(negedge clk);
        chk("en0_fall2", 32'(sw), 32'(0));
        chk("en0_state", 32'(state), 32'(0));

        // Retarget during BOUNCE: burst ends on the new level
        en = 1'b1;
        @(negedge clk);
        step_on_tick(1'b1, n_pred);
        watch(400, 2);
        chk("rt_edges", 32'(n_edges), 32'(2 * n_pred));
        chk("rt_final", 32'(sw), 32'(0));
        repeat (5) @(negedge clk);
        chk("rt_hold_sw",   32'(sw),   32'(0));
        chk("rt_hold_busy", 32'(busy), 32'(0));

        // Change during SETTLE restarts BOUNCE
        step_on_tick(1'b1, n_pred);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (state == 2'd2) found = 1'b1;
        end
        chk("st_reached", 32'(found), 32'(1));
        chk("st_sw", 32'(sw), 32'(1));
        level = 1'b0;
        @(negedge clk);
        chk("st_restart", 32'(state), 32'(1));
        chk("st_contact", 32'(sw), 32'(0));
        watch(400, 0);
        chk("st_final", 32'(sw), 32'(0));

        // Level high at reset release: burst starts at once, N from SEED = 2
        rst_n = 1'b0;
        level = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        watch(400, 0);
        chk("rel_edges", 32'(n_edges), 32'(5));
        chk("rel_first", 32'(edge_t[0]), 32'(1));
        chk("rel_second", 32'(edge_t[1]), 32'(8));
        chk("rel_final", 32'(sw), 32'(1));
        saved_n = n_edges;
        for (int i = 0; i < 32; i++) saved_t[i] = edge_t[i];

        // Reset mid-burst, then replay the same stimulus
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_sw",    32'(sw),    32'(0));
        chk("mid_rst_state", 32'(state), 32'(0));
        chk("mid_rst_busy",  32'(busy),  32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        watch(400, 0);
        chk("rep_edges", 32'(n_edges), 32'(saved_n));
        for (int i = 0; i < saved_n && i < 32; i++) begin
            chk("rep_edge_t", 32'(edge_t[i]), 32'(saved_t[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
